// File: rtl/vau_flag_pkg.sv
// vau_flag_pkg: shared types and constants for the VAU flag transmitter.
//   state_e      - operation tracking FSM states
//   PIN_*        - mprj_io pin numbers of the flag outputs
//   IO_OEB       - output-enable-bar pattern (pin 17 is an input)
//   io_bit()     - maps an mprj_io pin number to its io_out bit index
package vau_flag_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int PIN_OP_LSB  = 12;
  localparam int PIN_OPERAND = 16;
  localparam int PIN_CLK     = 17;
  localparam int PIN_ALU_RST = 18;

  localparam logic [6:0] IO_OEB = 7'b0100000;

  function automatic int io_bit(input int pin);
    return pin - PIN_OP_LSB;
  endfunction

endpackage

// File: rtl/vau_flag_tx_pulse.sv
// vau_pulse_stretch: stretches a single-cycle trigger into a registered
// pulse at least PULSE_STRETCH cycles long; a new trigger restarts the count.
//   clk   - clock (rising edge)
//   rst   - asynchronous active-high reset, kills any pending pulse
//   trig  - single-cycle trigger
//   pulse - registered stretched output
module vau_pulse_stretch #(
  parameter int PULSE_STRETCH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse
);

  localparam int CW = (PULSE_STRETCH > 1) ? $clog2(PULSE_STRETCH) : 1;

  // Cycles still to be held high after the current one.
  logic [CW-1:0] remain_r;

  // Trigger loads the remaining-cycle count; pulse stays high while it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain_r <= {CW{1'b0}};
      pulse    <= 1'b0;
    end else if (trig) begin
      remain_r <= CW'(PULSE_STRETCH - 1);
      pulse    <= 1'b1;
    end else if (remain_r != {CW{1'b0}}) begin
      remain_r <= remain_r - CW'(32'd1);
      pulse    <= 1'b1;
    end else begin
      remain_r <= {CW{1'b0}};
      pulse    <= 1'b0;
    end
  end

endmodule

// File: rtl/vau_flag_tx.sv
// vau_flag_tx: drives ALU status flags onto mprj_io[18:12] and measures
// how long each operation stays in RUN.
//   wb_clk_i     - clock
//   wb_rst_i     - asynchronous active-high reset
//   op_start     - start pulse, op_code sampled with it
//   op_code      - 4-bit operation code
//   operand_load - operand write pulse (only honoured in RUN)
//   op_done      - completion pulse (only honoured in RUN)
//   io_out       - {alu_rst, 0, operand, operation[3:0]}, all registered
//   io_oeb       - constant output-enable-bar
//   busy_cycles  - RUN length of the last finished or timed-out operation
//   timeout      - sticky: last operation was closed by the timeout
module vau_flag_tx
  import vau_flag_pkg::*;
#(
  parameter int          PULSE_STRETCH  = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        op_start,
  input  logic [3:0]  op_code,
  input  logic        operand_load,
  input  logic        op_done,
  output logic [6:0]  io_out,
  output logic [6:0]  io_oeb,
  output logic [31:0] busy_cycles,
  output logic        timeout
);

  localparam logic [31:0] HOLD_LAST = 32'(PULSE_STRETCH - 1);

  state_e      state_r;
  state_e      state_next_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_inc_s;
  logic [31:0] hold_cnt_r;
  logic [3:0]  op_code_r;
  logic [3:0]  operation_r;
  logic [3:0]  operation_next_s;
  logic        alu_rst_r;
  logic        alu_rst_next_s;
  logic        start_acc_s;
  logic        done_acc_s;
  logic        tmo_hit_s;
  logic        trig_s;
  logic        operand_s;

  assign io_oeb = IO_OEB;

  // Accepted events: each input only counts in the state that expects it.
  always_comb begin
    start_acc_s = (state_r == ST_IDLE) && op_start;
    done_acc_s  = (state_r == ST_RUN) && op_done;
    trig_s      = (state_r == ST_RUN) && operand_load;
    // Saturating increment so the counter can never wrap.
    cnt_inc_s   = (cnt_r == 32'hFFFF_FFFF) ? cnt_r : (cnt_r + 32'd1);
    // The edge that would make the count reach the limit closes the run.
    tmo_hit_s   = (state_r == ST_RUN) && (cnt_inc_s == TIMEOUT_CYCLES);
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; op_done takes priority over the timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (op_start) state_next_s = ST_RUN;
        else          state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (op_done || tmo_hit_s) state_next_s = ST_HOLD;
        else                      state_next_s = ST_RUN;
      end
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) state_next_s = ST_IDLE;
        else                         state_next_s = ST_HOLD;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so io_out changes on the sampling edge.
  always_comb begin
    alu_rst_next_s = (state_next_s == ST_IDLE);
    if (state_next_s == ST_IDLE) begin
      operation_next_s = 4'h0;
    end else if (start_acc_s) begin
      operation_next_s = op_code;
    end else begin
      operation_next_s = op_code_r;
    end
  end

  // Output registers for the FSM-driven flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      alu_rst_r   <= 1'b1;
      operation_r <= 4'h0;
    end else begin
      alu_rst_r   <= alu_rst_next_s;
      operation_r <= operation_next_s;
    end
  end

  // Cycle counter, HOLD length counter and latched op_code.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_r      <= 32'd0;
      hold_cnt_r <= 32'd0;
      op_code_r  <= 4'h0;
    end else begin
      if (start_acc_s) begin
        cnt_r     <= 32'd0;
        op_code_r <= op_code;
      end else if (state_r == ST_RUN) begin
        cnt_r     <= cnt_inc_s;
        op_code_r <= op_code_r;
      end else begin
        cnt_r     <= cnt_r;
        op_code_r <= op_code_r;
      end
      if ((state_r == ST_HOLD) && (state_next_s == ST_HOLD)) begin
        hold_cnt_r <= hold_cnt_r + 32'd1;
      end else begin
        hold_cnt_r <= 32'd0;
      end
    end
  end

  // Result registers: busy length and sticky timeout flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      busy_cycles <= 32'd0;
      timeout     <= 1'b0;
    end else if (start_acc_s) begin
      busy_cycles <= busy_cycles;
      timeout     <= 1'b0;
    end else if (done_acc_s) begin
      busy_cycles <= cnt_inc_s;
      timeout     <= timeout;
    end else if (tmo_hit_s) begin
      busy_cycles <= TIMEOUT_CYCLES;
      timeout     <= 1'b1;
    end else begin
      busy_cycles <= busy_cycles;
      timeout     <= timeout;
    end
  end

  vau_pulse_stretch #(
    .PULSE_STRETCH(PULSE_STRETCH)
  ) u_operand_stretch (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .trig  (trig_s),
    .pulse (operand_s)
  );

  // Pin assembly; pin 17 is the external clock input and is never driven.
  always_comb begin
    io_out                                = 7'b0000000;
    io_out[io_bit(PIN_ALU_RST)]           = alu_rst_r;
    io_out[io_bit(PIN_OPERAND)]           = operand_s;
    io_out[io_bit(PIN_OP_LSB + 3):0]      = operation_r;
  end

endmodule

// File: tb/tb_vau_flag_tx.sv
// tb_vau_flag_tx: randomized and directed stimulus for vau_flag_tx, checked
// every cycle against an event-timestamp model, plus literal expectations.
module tb_vau_flag_tx;

  localparam int PS = 4;
  localparam int T  = 20;

  logic        clk;
  logic        wb_rst_i;
  logic        op_start;
  logic [3:0]  op_code;
  logic        operand_load;
  logic        op_done;
  logic [6:0]  io_out;
  logic [6:0]  io_oeb;
  logic [31:0] busy_cycles;
  logic        timeout;

  vau_flag_tx #(
    .PULSE_STRETCH (PS),
    .TIMEOUT_CYCLES(32'd20)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .op_start    (op_start),
    .op_code     (op_code),
    .operand_load(operand_load),
    .op_done     (op_done),
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .busy_cycles (busy_cycles),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: operation described by edge timestamps rather than counters.
  int          e          = 0;
  bit          m_active   = 0;
  bit          m_hold     = 0;
  int          start_e    = 0;
  int          hold_end   = 0;
  int          pulse_last = -1;
  logic [3:0]  m_code     = 4'h0;
  logic [31:0] m_busy     = 32'd0;
  bit          m_tmo      = 0;

  int low_cnt  = 0;
  int op_cnt   = 0;
  int code_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    int k;
    e++;
    if (wb_rst_i) begin
      m_active = 0; m_hold = 0; m_busy = 32'd0; m_tmo = 0;
      pulse_last = -1; m_code = 4'h0;
    end else begin
      if (m_active && operand_load) pulse_last = e + PS - 1;
      if (m_hold) begin
        if (e == hold_end) m_hold = 0;
      end else if (m_active) begin
        k = e - start_e;
        if (op_done) begin
          m_busy = k; m_active = 0; m_hold = 1; hold_end = e + PS;
        end else if (k == T) begin
          m_busy = T; m_tmo = 1; m_active = 0; m_hold = 1; hold_end = e + PS;
        end
      end else if (op_start) begin
        m_active = 1; start_e = e; m_code = op_code; m_tmo = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic       idle;
    logic [6:0] exp_io;
    idle   = !m_active && !m_hold;
    exp_io = {idle, 1'b0, (e <= pulse_last), (idle ? 4'h0 : m_code)};
    check("io_out", {25'd0, io_out}, {25'd0, exp_io});
    check("io_oeb", {25'd0, io_oeb}, 32'h0000_0020);
    check("busy_cycles", busy_cycles, m_busy);
    check("timeout", {31'd0, timeout}, {31'd0, m_tmo});
  endtask

  task automatic cyc(input logic st, input logic [3:0] oc, input logic ol, input logic od);
    op_start = st; op_code = oc; operand_load = ol; op_done = od;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (!io_out[6]) low_cnt++;
    if (io_out[4]) op_cnt++;
    if (io_out[3:0] == 4'hA) code_cnt++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic normal_op();
    low_cnt = 0; code_cnt = 0;
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    idle_n(9);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    idle_n(6);
    check("normal_busy", busy_cycles, 32'd10);
    check("normal_low_window", low_cnt, 32'd14);
    check("normal_code_window", code_cnt, 32'd14);
  endtask

  initial begin
    wb_rst_i = 1'b1; op_start = 1'b0; op_code = 4'h0;
    operand_load = 1'b0; op_done = 1'b0;
    idle_n(2);
    check("rst_io_out", {25'd0, io_out}, 32'h0000_0040);
    check("rst_io_oeb", {25'd0, io_oeb}, 32'h0000_0020);
    check("rst_busy", busy_cycles, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    wb_rst_i = 1'b0;
    idle_n(2);

    normal_op();

    // Operand pulses: retriggered pair, then an isolated one.
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    op_cnt = 0;
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    idle_n(1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    idle_n(6);
    check("operand_retrigger_len", op_cnt, 32'd6);
    op_cnt = 0;
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    idle_n(5);
    check("operand_single_len", op_cnt, 32'd4);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    idle_n(6);

    // Timeout with no op_done.
    low_cnt = 0;
    cyc(1'b1, 4'h5, 1'b0, 1'b0);
    idle_n(30);
    check("tmo_flag", {31'd0, timeout}, 32'd1);
    check("tmo_busy", busy_cycles, 32'd20);
    check("tmo_low_window", low_cnt, 32'd24);
    cyc(1'b1, 4'h6, 1'b0, 1'b0);
    check("tmo_cleared_by_start", {31'd0, timeout}, 32'd0);
    idle_n(3);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    idle_n(6);

    // Collision: ignored start in RUN, done on the timeout edge.
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    check("start_in_run_code", {28'd0, io_out[3:0]}, 32'd7);
    idle_n(18);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("coll_timeout", {31'd0, timeout}, 32'd0);
    check("coll_busy", busy_cycles, 32'd20);
    idle_n(6);

    // Mid-RUN reset with the operand pulse active.
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    idle_n(1);
    check("pre_rst_operand", {31'd0, io_out[4]}, 32'd1);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_io_out", {25'd0, io_out}, 32'h0000_0040);
    check("midrst_busy", busy_cycles, 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    wb_rst_i = 1'b0;
    idle_n(1);
    normal_op();

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      wb_rst_i = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end
    wb_rst_i = 1'b0;
    idle_n(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
